imem_dmem_arbiter: RTL and testbench
====================================

Name: imem_dmem_arbiter

Overview:
- Shares one single-ported external memory between the IF stage (instruction fetch) and the MEM stage (load/store).
- Sequences each access with a req/ready handshake and drives the stall signals that feed the pipeline freeze logic.
- Discards an in-flight fetch when a branch redirects the IF stage.
- Sits between IF_Stage/MEM stage and the memory model, beside the hazard unit.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
if_req  in  1  fetch request, level; held with stable if_addr until if_ready
if_addr  in  ADDR_W  fetch address (PC)
if_rdata  out  DATA_W  fetched instruction, valid while if_ready=1
if_ready  out  1  one-cycle fetch-complete pulse
flush  in  1  Branch_taken; cancels the in-flight fetch
mem_req  in  1  data request, level; held stable until mem_ready
mem_we  in  1  1=store, 0=load
mem_addr  in  ADDR_W  data address
mem_wdata  in  DATA_W  store data
mem_rdata  out  DATA_W  load data, valid while mem_ready=1
mem_ready  out  1  one-cycle data-complete pulse
ext_en  out  1  external access active
ext_we  out  1  external write enable
ext_addr  out  ADDR_W  external address
ext_wdata  out  DATA_W  external write data
ext_rdata  in  DATA_W  external read data, valid with ext_ack
ext_ack  in  1  access complete, latency 1..N cycles after ext_en rises
if_stall  out  1  if_req & ~if_ready
mem_stall  out  1  mem_req & ~mem_ready
freeze  out  1  if_stall | mem_stall

Behaviour:
- FSM states: IDLE, IF_BUSY, MEM_BUSY, IF_DONE, MEM_DONE. State, ext_* and rdata outputs are registered.
- Reset (async): state=IDLE, ext_en=0, ext_we=0, ext_addr=0, ext_wdata=0, if_ready=0, mem_ready=0, if_rdata=0, mem_rdata=0, discard=0.
- A reset mid-access abandons the access; the external memory must tolerate ext_en dropping.
- IDLE: at the clock edge, mem_req has priority over if_req (older instruction).
  - mem_req → MEM_BUSY; latch mem_addr, mem_wdata, mem_we into ext_*; ext_en=1.
  - else if_req → IF_BUSY; latch if_addr; ext_we=0; ext_en=1.
- BUSY: ext_* are held constant until the ext_ack edge. On ext_ack:
  - latch ext_rdata into if_rdata or mem_rdata;
  - ext_en=0;
  - go to the matching DONE state.
- DONE: the matching ready=1 for exactly one cycle, then IDLE. The requester samples ready at that edge and drops req.
- Minimum access period is ack latency + 2 cycles. A new grant is never issued in the DONE cycle.
- Store (mem_we=1): mem_ready pulses normally; mem_rdata is updated with ext_rdata but is don't-care.
- Flush:
  - flush=1 in IF_BUSY sets discard. The access still completes (no abort).
  - On ext_ack with discard=1: go directly to IDLE, clear discard, if_ready stays 0, if_rdata unchanged.
  - flush=1 in IF_DONE suppresses if_ready that cycle.
  - flush has no effect in IDLE, MEM_BUSY or MEM_DONE.
- Simultaneous flush and ext_ack in IF_BUSY: the fetch is discarded.
- Simultaneous if_req and mem_req: MEM is served first. IF waits; if_stall stays 1 throughout.
- No starvation guarantee is required beyond the pipeline freezing during MEM stalls.
- Stall outputs are combinational from req and ready.

Test Plan:
- Reset then if_req=1, if_addr=0x00000004, ext_ack after 2 cycles with ext_rdata=0xE3A01005 → if_ready pulses one cycle, if_rdata=0xE3A01005, if_stall=1 until that cycle, ext_addr=0x4 held stable.
- if_req and mem_req (load, addr 0x100) raised together → MEM granted first: ext_addr=0x100, mem_ready pulses; then IF granted; freeze=1 until if_ready.
- Store mem_we=1, addr 0x200, wdata 0xDEADBEEF → ext_we=1, ext_wdata=0xDEADBEEF held until ext_ack; mem_ready pulses once; ext_en=0 afterward.
- flush pulsed during IF_BUSY (if_addr 0x8) → after ext_ack, if_ready never asserts, if_rdata unchanged, FSM in IDLE. Next if_req at 0x20 → fetch of 0x20 returns normally.
- Assert rst during MEM_BUSY → ext_en=0, mem_ready=0, state IDLE immediately (asynchronous). After rst falls, a pending mem_req is re-granted.
- Back-to-back fetches 0x0, 0x4, 0x8 with 1-cycle ack → each if_ready exactly 3 cycles apart. No grant occurs while a DONE state is active.

Source files
------------

// File: rtl/imem_dmem_arbiter.sv
// Arbitrates one single-ported external memory between instruction fetch and
// load/store traffic, generating the stall/freeze signals for the pipeline.
module imem_dmem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_if_req,
  input  logic [ADDR_W-1:0] i_if_addr,
  output logic [DATA_W-1:0] o_if_rdata,
  output logic              o_if_ready,
  input  logic              i_flush,
  input  logic              i_mem_req,
  input  logic              i_mem_we,
  input  logic [ADDR_W-1:0] i_mem_addr,
  input  logic [DATA_W-1:0] i_mem_wdata,
  output logic [DATA_W-1:0] o_mem_rdata,
  output logic              o_mem_ready,
  output logic              o_ext_en,
  output logic              o_ext_we,
  output logic [ADDR_W-1:0] o_ext_addr,
  output logic [DATA_W-1:0] o_ext_wdata,
  input  logic [DATA_W-1:0] i_ext_rdata,
  input  logic              i_ext_ack,
  output logic              o_if_stall,
  output logic              o_mem_stall,
  output logic              o_freeze
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_IF_BUSY,
    S_MEM_BUSY,
    S_IF_DONE,
    S_MEM_DONE
  } state_t;

  state_t            r_state;
  logic              r_ext_en;
  logic              r_ext_we;
  logic [ADDR_W-1:0] r_ext_addr;
  logic [DATA_W-1:0] r_ext_wdata;
  logic              r_if_ready;
  logic              r_mem_ready;
  logic [DATA_W-1:0] r_if_rdata;
  logic [DATA_W-1:0] r_mem_rdata;
  logic              r_discard;
  logic              w_if_ready;

  // NOTE: all state updates use non-blocking assignments so every branch sees
  // the pre-edge values, regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_ext_en    <= 1'b0;
      r_ext_we    <= 1'b0;
      r_ext_addr  <= '0;
      r_ext_wdata <= '0;
      r_if_ready  <= 1'b0;
      r_mem_ready <= 1'b0;
      r_if_rdata  <= '0;
      r_mem_rdata <= '0;
      r_discard   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          // Data access wins: it belongs to the older instruction.
          if (i_mem_req) begin
            r_state     <= S_MEM_BUSY;
            r_ext_en    <= 1'b1;
            r_ext_we    <= i_mem_we;
            r_ext_addr  <= i_mem_addr;
            r_ext_wdata <= i_mem_wdata;
          end else if (i_if_req) begin
            r_state    <= S_IF_BUSY;
            r_ext_en   <= 1'b1;
            r_ext_we   <= 1'b0;
            r_ext_addr <= i_if_addr;
          end
        end
        S_IF_BUSY: begin
          if (i_ext_ack) begin
            r_ext_en  <= 1'b0;
            r_discard <= 1'b0;
            // A fetch redirected by a branch still drains, but its data is dropped.
            if (r_discard || i_flush) begin
              r_state <= S_IDLE;
            end else begin
              r_if_rdata <= i_ext_rdata;
              r_if_ready <= 1'b1;
              r_state    <= S_IF_DONE;
            end
          end else if (i_flush) begin
            r_discard <= 1'b1;
          end
        end
        S_MEM_BUSY: begin
          if (i_ext_ack) begin
            r_ext_en    <= 1'b0;
            r_mem_rdata <= i_ext_rdata;
            r_mem_ready <= 1'b1;
            r_state     <= S_MEM_DONE;
          end
        end
        S_IF_DONE: begin
          r_if_ready <= 1'b0;
          r_state    <= S_IDLE;
        end
        S_MEM_DONE: begin
          r_mem_ready <= 1'b0;
          r_state     <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // A branch arriving in the completion cycle must still kill the fetch.
  assign w_if_ready  = r_if_ready & ~i_flush;

  assign o_if_ready  = w_if_ready;
  assign o_if_rdata  = r_if_rdata;
  assign o_mem_ready = r_mem_ready;
  assign o_mem_rdata = r_mem_rdata;
  assign o_ext_en    = r_ext_en;
  assign o_ext_we    = r_ext_we;
  assign o_ext_addr  = r_ext_addr;
  assign o_ext_wdata = r_ext_wdata;

  assign o_if_stall  = i_if_req & ~w_if_ready;
  assign o_mem_stall = i_mem_req & ~r_mem_ready;
  assign o_freeze    = o_if_stall | o_mem_stall;

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Directed bench for imem_dmem_arbiter: a latency-programmable memory model
// answers ext_* accesses, and a scoreboard checks every ready pulse.
module tb_imem_dmem_arbiter;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ready;
  logic        flush;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        ext_en;
  logic        ext_we;
  logic [31:0] ext_addr;
  logic [31:0] ext_wdata;
  logic [31:0] ext_rdata;
  logic        ext_ack;
  logic        if_stall;
  logic        mem_stall;
  logic        freeze;

  imem_dmem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_if_req   (if_req),
    .i_if_addr  (if_addr),
    .o_if_rdata (if_rdata),
    .o_if_ready (if_ready),
    .i_flush    (flush),
    .i_mem_req  (mem_req),
    .i_mem_we   (mem_we),
    .i_mem_addr (mem_addr),
    .i_mem_wdata(mem_wdata),
    .o_mem_rdata(mem_rdata),
    .o_mem_ready(mem_ready),
    .o_ext_en   (ext_en),
    .o_ext_we   (ext_we),
    .o_ext_addr (ext_addr),
    .o_ext_wdata(ext_wdata),
    .i_ext_rdata(ext_rdata),
    .i_ext_ack  (ext_ack),
    .o_if_stall (if_stall),
    .o_mem_stall(mem_stall),
    .o_freeze   (freeze)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // External memory model: ack `lat` cycles after ext_en rises.
  logic [31:0] model_mem [logic [31:0]];
  int          lat     = 1;
  int          ack_cnt = 0;

  function automatic logic [31:0] model_rd(input logic [31:0] a);
    if (model_mem.exists(a)) return model_mem[a];
    return 32'hBAD0_0000 | {16'h0, a[15:0]};
  endfunction

  initial begin
    ext_ack   = 1'b0;
    ext_rdata = '0;
  end

  always @(negedge clk) begin
    if (ext_en && !ext_ack) begin
      ack_cnt++;
      if (ack_cnt >= lat) begin
        ext_ack   = 1'b1;
        ext_rdata = model_rd(ext_addr);
        if (ext_we) model_mem[ext_addr] = ext_wdata;
        ack_cnt   = 0;
      end
    end else begin
      ext_ack = 1'b0;
      ack_cnt = 0;
    end
  end

  // Scoreboard: expectations pushed with the stimulus, popped on each ready pulse.
  typedef struct {
    bit          store;
    logic [31:0] data;
  } mem_exp_t;

  logic [31:0] if_q [$];
  mem_exp_t    mem_q [$];
  logic [31:0] if_exp;
  mem_exp_t    mem_exp;

  always @(negedge clk) begin
    if (if_ready) begin
      if (if_q.size() == 0) begin
        check("if_unexpected_ready", {31'h0, if_ready}, 32'h0);
      end else begin
        if_exp = if_q.pop_front();
        check("if_rdata", if_rdata, if_exp);
      end
    end
    if (mem_ready) begin
      if (mem_q.size() == 0) begin
        check("mem_unexpected_ready", {31'h0, mem_ready}, 32'h0);
      end else begin
        mem_exp = mem_q.pop_front();
        if (!mem_exp.store) check("mem_rdata", mem_rdata, mem_exp.data);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits for a ready pulse, checking stalls and held ext_* fields on the way.
  task automatic wait_ready(input bit is_mem, input logic [31:0] exp_addr, input bit exp_we,
                            input logic [31:0] exp_wdata, output int cycles);
    logic  rdy;
    string pfx;
    if (is_mem) pfx = "mem";
    else        pfx = "if";
    cycles = 0;
    rdy    = is_mem ? mem_ready : if_ready;
    while (!rdy && cycles < 20) begin
      @(negedge clk);
      cycles++;
      rdy = is_mem ? mem_ready : if_ready;
      if (!rdy) begin
        check({pfx, "_stall_wait"}, {31'h0, is_mem ? mem_stall : if_stall}, 32'h1);
        check("freeze_wait", {31'h0, freeze}, 32'h1);
        if (ext_en) begin
          check("ext_addr_held", ext_addr, exp_addr);
          check("ext_we_held", {31'h0, ext_we}, {31'h0, exp_we});
          if (exp_we) check("ext_wdata_held", ext_wdata, exp_wdata);
        end
      end
    end
    check({pfx, "_ready_timeout"}, {31'h0, rdy}, 32'h1);
    check("ext_en_in_done", {31'h0, ext_en}, 32'h0);
    check({pfx, "_stall_in_done"}, {31'h0, is_mem ? mem_stall : if_stall}, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  int cycles;
  int t0, t1, t2;

  initial begin
    rst = 1'b1; if_req = 1'b0; if_addr = '0; flush = 1'b0;
    mem_req = 1'b0; mem_we = 1'b0; mem_addr = '0; mem_wdata = '0;
    model_mem[32'h0000_0004] = 32'hE3A0_1005;
    model_mem[32'h0000_0040] = 32'h3333_4444;
    model_mem[32'h0000_0100] = 32'h1111_2222;
    model_mem[32'h0000_0008] = 32'h9999_9999;
    model_mem[32'h0000_0020] = 32'h2020_2020;
    model_mem[32'h0000_0300] = 32'h5555_AAAA;
    model_mem[32'h0000_0000] = 32'hA000_0000;
    model_mem[32'h0000_0030] = 32'h3030_3030;

    // Reset state
    @(negedge clk);
    check("rst_ext_en",    {31'h0, ext_en},    32'h0);
    check("rst_ext_we",    {31'h0, ext_we},    32'h0);
    check("rst_ext_addr",  ext_addr,           32'h0);
    check("rst_ext_wdata", ext_wdata,          32'h0);
    check("rst_if_ready",  {31'h0, if_ready},  32'h0);
    check("rst_mem_ready", {31'h0, mem_ready}, 32'h0);
    check("rst_if_rdata",  if_rdata,           32'h0);
    check("rst_mem_rdata", mem_rdata,          32'h0);
    tick();
    rst = 1'b0;

    // Single fetch, 2-cycle ack
    lat = 2;
    if_addr = 32'h4; if_req = 1'b1;
    if_q.push_back(32'hE3A0_1005);
    wait_ready(1'b0, 32'h4, 1'b0, 32'h0, cycles);
    check("fetch_latency", cycles, 32'd4);
    tick();
    if_req = 1'b0;
    @(negedge clk);
    check("if_ready_one_cycle", {31'h0, if_ready}, 32'h0);
    check("if_stall_idle", {31'h0, if_stall}, 32'h0);

    // Simultaneous load and fetch: data side first
    tick();
    if_addr = 32'h40; if_req = 1'b1;
    mem_addr = 32'h100; mem_we = 1'b0; mem_req = 1'b1;
    mem_q.push_back('{store: 1'b0, data: 32'h1111_2222});
    if_q.push_back(32'h3333_4444);
    wait_ready(1'b1, 32'h100, 1'b0, 32'h0, cycles);
    check("if_waits_ready", {31'h0, if_ready}, 32'h0);
    check("if_waits_stall", {31'h0, if_stall}, 32'h1);
    check("if_waits_freeze", {31'h0, freeze}, 32'h1);
    tick();
    mem_req = 1'b0;
    wait_ready(1'b0, 32'h40, 1'b0, 32'h0, cycles);
    tick();
    if_req = 1'b0;

    // Store, 3-cycle ack, then read back
    lat = 3;
    mem_addr = 32'h200; mem_wdata = 32'hDEAD_BEEF; mem_we = 1'b1; mem_req = 1'b1;
    mem_q.push_back('{store: 1'b1, data: 32'h0});
    wait_ready(1'b1, 32'h200, 1'b1, 32'hDEAD_BEEF, cycles);
    tick();
    mem_req = 1'b0; mem_we = 1'b0;
    @(negedge clk);
    check("store_ext_en_after", {31'h0, ext_en}, 32'h0);
    check("store_ready_once", {31'h0, mem_ready}, 32'h0);
    check("store_written", model_rd(32'h200), 32'hDEAD_BEEF);
    tick();
    mem_req = 1'b1;
    mem_q.push_back('{store: 1'b0, data: 32'hDEAD_BEEF});
    wait_ready(1'b1, 32'h200, 1'b0, 32'h0, cycles);
    tick();
    mem_req = 1'b0;

    // Flush during IF_BUSY, then redirected fetch at 0x20
    if_addr = 32'h8; if_req = 1'b1;
    tick();
    flush = 1'b1; if_addr = 32'h20;
    if_q.push_back(32'h2020_2020);
    tick();
    flush = 1'b0;
    repeat (3) @(negedge clk);
    check("flush_no_ready", {31'h0, if_ready}, 32'h0);
    check("flush_rdata_kept", if_rdata, 32'h3333_4444);
    check("flush_ext_en_idle", {31'h0, ext_en}, 32'h0);
    wait_ready(1'b0, 32'h20, 1'b0, 32'h0, cycles);
    tick();
    if_req = 1'b0;

    // Asynchronous reset during MEM_BUSY, then re-grant
    lat = 4;
    mem_addr = 32'h300; mem_we = 1'b0; mem_req = 1'b1;
    tick();
    @(negedge clk);
    check("busy_ext_en", {31'h0, ext_en}, 32'h1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_ext_en", {31'h0, ext_en}, 32'h0);
    check("async_rst_ext_addr", ext_addr, 32'h0);
    check("async_rst_mem_ready", {31'h0, mem_ready}, 32'h0);
    tick();
    rst = 1'b0;
    mem_q.push_back('{store: 1'b0, data: 32'h5555_AAAA});
    wait_ready(1'b1, 32'h300, 1'b0, 32'h0, cycles);
    tick();
    mem_req = 1'b0;

    // Back-to-back fetches with 1-cycle ack
    lat = 1;
    if_addr = 32'h0; if_req = 1'b1;
    if_q.push_back(32'hA000_0000);
    if_q.push_back(32'hE3A0_1005);
    if_q.push_back(32'h9999_9999);
    wait_ready(1'b0, 32'h0, 1'b0, 32'h0, cycles);
    t0 = cyc;
    tick();
    if_addr = 32'h4;
    wait_ready(1'b0, 32'h4, 1'b0, 32'h0, cycles);
    t1 = cyc;
    tick();
    if_addr = 32'h8;
    wait_ready(1'b0, 32'h8, 1'b0, 32'h0, cycles);
    t2 = cyc;
    check("b2b_spacing_1", t1 - t0, 32'd3);
    check("b2b_spacing_2", t2 - t1, 32'd3);
    tick();
    if_req = 1'b0;

    // Flush arriving in the IF_DONE cycle suppresses if_ready
    if_addr = 32'h30; if_req = 1'b1;
    tick();
    tick();
    flush = 1'b1;
    @(negedge clk);
    check("done_flush_ready", {31'h0, if_ready}, 32'h0);
    check("done_flush_stall", {31'h0, if_stall}, 32'h1);
    tick();
    flush = 1'b0; if_req = 1'b0;
    @(negedge clk);
    check("done_flush_after", {31'h0, if_ready}, 32'h0);

    repeat (3) tick();
    check("if_q_drained", if_q.size(), 32'd0);
    check("mem_q_drained", mem_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
